// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative RV32M multiply/divide unit for the EX stage
module ex_muldiv_unit #(
   parameter int FAST_MUL = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  ex_opcode,
   input  logic [6:0]  ex_func7,
   input  logic [2:0]  ex_func3,
   input  logic [31:0] ex_op1,
   input  logic [31:0] ex_op2,
   input  logic        ex_forward_pipeline_flush,
   input  logic        ex_kill,
   output logic        muldiv_sel,
   output logic        muldiv_busy,
   output logic        muldiv_done,
   output logic [31:0] muldiv_result
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [31:0] a_q, a_d;        // |op1|: multiplicand
   logic [31:0] b_q, b_d;        // |op2|: divisor
   logic [63:0] acc_q, acc_d;    // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
   logic [4:0]  cnt_q, cnt_d;
   logic        neg_q, neg_d;
   logic [2:0]  func3_q, func3_d;
   logic        done_q, done_d;
   logic [31:0] result_q, result_d;

   logic        is_m;
   logic        s1, s2, n1, n2, neg_new;
   logic [31:0] abs1, abs2;
   logic [63:0] fast_a, fast_b, fast_p;
   logic [31:0] fast_res;
   logic [32:0] mul_sum;
   logic [63:0] mul_acc, mul_prod;
   logic [32:0] div_rem_sh;
   logic        div_geq;
   logic [31:0] div_rem;
   logic [63:0] div_acc;
   logic [31:0] div_out, div_res;

   assign is_m          = (ex_opcode == 7'b0110011) && (ex_func7 == 7'b0000001)
                          && !ex_forward_pipeline_flush;
   assign muldiv_sel    = is_m;
   assign muldiv_busy   = ((state_q == S_IDLE) && is_m && !ex_kill)
                          || (state_q == S_MUL) || (state_q == S_DIV);
   assign muldiv_done   = done_q;
   assign muldiv_result = result_q;

   // Operand signedness, magnitudes, result sign and one-cycle product
   always_comb begin
      s1 = 1'b0;
      s2 = 1'b0;
      case (ex_func3)
         3'b000, 3'b001, 3'b100, 3'b110: begin s1 = 1'b1; s2 = 1'b1; end
         3'b010:                         begin s1 = 1'b1; s2 = 1'b0; end
         default:                        begin s1 = 1'b0; s2 = 1'b0; end
      endcase
      n1       = s1 & ex_op1[31];
      n2       = s2 & ex_op2[31];
      abs1     = n1 ? -ex_op1 : ex_op1;
      abs2     = n2 ? -ex_op2 : ex_op2;
      // REM takes the dividend's sign; every other signed op uses the xor
      neg_new  = (ex_func3 == 3'b110) ? n1 : (n1 ^ n2);
      fast_a   = {{32{n1}}, ex_op1};
      fast_b   = {{32{n2}}, ex_op2};
      fast_p   = fast_a * fast_b;
      fast_res = (ex_func3[1:0] == 2'b00) ? fast_p[31:0] : fast_p[63:32];
   end

   // One shift-add step and one restoring-division step, plus sign fixup
   always_comb begin
      mul_sum    = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);
      mul_acc    = {mul_sum, acc_q[31:1]};
      mul_prod   = neg_q ? -mul_acc : mul_acc;
      div_rem_sh = acc_q[63:31];
      div_geq    = div_rem_sh >= {1'b0, b_q};
      div_rem    = div_geq ? (div_rem_sh[31:0] - b_q) : div_rem_sh[31:0];
      div_acc    = {div_rem, acc_q[30:0], div_geq};
      div_out    = func3_q[1] ? div_acc[63:32] : div_acc[31:0];
      div_res    = neg_q ? -div_out : div_out;
   end

   // Next-state logic: start, iterate, finish; a kill overrides everything
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      func3_d  = func3_q;
      done_d   = 1'b0;
      result_d = result_q;
      case (state_q)
         S_IDLE: begin
            if (is_m && !ex_kill) begin
               a_d     = abs1;
               b_d     = abs2;
               neg_d   = neg_new;
               func3_d = ex_func3;
               cnt_d   = 5'd0;
               acc_d   = {32'd0, (ex_func3[2] ? abs1 : abs2)};
               if (ex_func3[2] && (ex_op2 == 32'd0)) begin
                  state_d  = S_DONE;
                  done_d   = 1'b1;
                  result_d = ex_func3[1] ? ex_op1 : 32'hFFFFFFFF;
               end else if (ex_func3[2] && !ex_func3[0] && (ex_op1 == 32'h80000000)
                            && (ex_op2 == 32'hFFFFFFFF)) begin
                  state_d  = S_DONE;
                  done_d   = 1'b1;
                  result_d = ex_func3[1] ? 32'd0 : 32'h80000000;
               end else if (!ex_func3[2] && (FAST_MUL != 0)) begin
                  state_d  = S_DONE;
                  done_d   = 1'b1;
                  result_d = fast_res;
               end else begin
                  state_d = ex_func3[2] ? S_DIV : S_MUL;
               end
            end
         end
         S_MUL: begin
            acc_d = mul_acc;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d  = S_DONE;
               done_d   = 1'b1;
               result_d = (func3_q[1:0] == 2'b00) ? mul_prod[31:0] : mul_prod[63:32];
            end
         end
         S_DIV: begin
            acc_d = div_acc;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d  = S_DONE;
               done_d   = 1'b1;
               result_d = div_res;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (ex_kill) begin
         state_d  = S_IDLE;
         done_d   = 1'b0;
         result_d = result_q;
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         a_q      <= 32'd0;
         b_q      <= 32'd0;
         acc_q    <= 64'd0;
         cnt_q    <= 5'd0;
         neg_q    <= 1'b0;
         func3_q  <= 3'd0;
         done_q   <= 1'b0;
         result_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         func3_q  <= func3_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - directed self-checking bench for ex_muldiv_unit
module tb_ex_muldiv_unit;

   logic        clk;
   logic        rst;
   logic [6:0]  ex_opcode;
   logic [6:0]  ex_func7;
   logic [2:0]  ex_func3;
   logic [31:0] ex_op1;
   logic [31:0] ex_op2;
   logic        ex_flush;
   logic        ex_kill;
   logic        sel_s, busy_s, done_s;
   logic [31:0] res_s;
   logic        sel_f, busy_f, done_f;
   logic [31:0] res_f;

   int checks;
   int failures;
   logic [31:0] last_res;

   ex_muldiv_unit #(.FAST_MUL(0)) dut_s (
      .clk(clk), .rst(rst), .ex_opcode(ex_opcode), .ex_func7(ex_func7),
      .ex_func3(ex_func3), .ex_op1(ex_op1), .ex_op2(ex_op2),
      .ex_forward_pipeline_flush(ex_flush), .ex_kill(ex_kill),
      .muldiv_sel(sel_s), .muldiv_busy(busy_s), .muldiv_done(done_s),
      .muldiv_result(res_s)
   );

   ex_muldiv_unit #(.FAST_MUL(1)) dut_f (
      .clk(clk), .rst(rst), .ex_opcode(ex_opcode), .ex_func7(ex_func7),
      .ex_func3(ex_func3), .ex_op1(ex_op1), .ex_op2(ex_op2),
      .ex_forward_pipeline_flush(ex_flush), .ex_kill(ex_kill),
      .muldiv_sel(sel_f), .muldiv_busy(busy_f), .muldiv_done(done_f),
      .muldiv_result(res_f)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_nop();
      ex_opcode = 7'b0010011;
      ex_func7  = 7'd0;
      ex_func3  = 3'd0;
      ex_op1    = 32'd0;
      ex_op2    = 32'd0;
      ex_flush  = 1'b0;
      ex_kill   = 1'b0;
   endtask

   task automatic set_mop(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      ex_opcode = 7'b0110011;
      ex_func7  = 7'b0000001;
      ex_func3  = f3;
      ex_op1    = a;
      ex_op2    = b;
      ex_flush  = 1'b0;
      ex_kill   = 1'b0;
   endtask

   task automatic run_op(input string name, input logic fast, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_stall);
      int stalls;
      stalls = 0;
      set_mop(f3, a, b);
      @(negedge clk);
      checks++;
      if ((fast ? sel_f : sel_s) !== 1'b1) begin
         failures++;
         $display("FAIL %s_sel got=%b want=1", name, (fast ? sel_f : sel_s));
      end
      while ((fast ? busy_f : busy_s) === 1'b1 && stalls < 100) begin
         stalls++;
         @(negedge clk);
      end
      checks++;
      if (stalls !== exp_stall) begin
         failures++;
         $display("FAIL %s_stalls got=%0d want=%0d", name, stalls, exp_stall);
      end
      checks++;
      if ((fast ? done_f : done_s) !== 1'b1) begin
         failures++;
         $display("FAIL %s_done got=%b want=1", name, (fast ? done_f : done_s));
      end
      checks++;
      if ((fast ? res_f : res_s) !== exp_res) begin
         failures++;
         $display("FAIL %s_result got=%h want=%h", name, (fast ? res_f : res_s), exp_res);
      end
      last_res = exp_res;
      @(posedge clk);
      #1;
      set_nop();
   endtask

   task automatic test_reset();
      set_nop();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({sel_s, busy_s, done_s, res_s} !== 35'd0) begin
         failures++;
         $display("FAIL reset_slow got=%b%b%b_%h want=000_00000000", sel_s, busy_s, done_s, res_s);
      end
      checks++;
      if ({sel_f, busy_f, done_f, res_f} !== 35'd0) begin
         failures++;
         $display("FAIL reset_fast got=%b%b%b_%h want=000_00000000", sel_f, busy_f, done_f, res_f);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_fast_mul();
      run_op("fmul",    1'b1, 3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1);
      run_op("fmulh",   1'b1, 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1);
      run_op("fmulhsu", 1'b1, 3'b010, 32'h80000000, 32'h80000000, 32'hC0000000, 1);
      run_op("fmulhu",  1'b1, 3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 1);
      // let the iterative unit finish the multiply it picked up meanwhile
      repeat (40) @(posedge clk);
      #1;
   endtask

   task automatic test_mul();
      run_op("mul",    1'b0, 3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
      run_op("mulh",   1'b0, 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
      run_op("mulhsu", 1'b0, 3'b010, 32'h80000000, 32'h80000000, 32'hC0000000, 33);
      run_op("mulhu",  1'b0, 3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 33);
   endtask

   task automatic test_div();
      run_op("div",  1'b0, 3'b100, 32'hFFFFFFF9, 32'd2,  32'hFFFFFFFD, 33);
      run_op("rem",  1'b0, 3'b110, 32'hFFFFFFF9, 32'd2,  32'hFFFFFFFF, 33);
      run_op("divu", 1'b0, 3'b101, 32'hFFFFFFFF, 32'd16, 32'h0FFFFFFF, 33);
   endtask

   task automatic test_special();
      run_op("div0",  1'b0, 3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
      run_op("remu0", 1'b0, 3'b111, 32'd5,        32'd0,        32'd5,        1);
      run_op("divov", 1'b0, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
      run_op("remov", 1'b0, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);
   endtask

   task automatic test_kill();
      int saw_done;
      saw_done = 0;
      set_mop(3'b101, 32'd100, 32'd7);
      repeat (11) @(posedge clk);
      #1;
      ex_kill = 1'b1;
      @(negedge clk);
      checks++;
      if (busy_s !== 1'b1) begin
         failures++;
         $display("FAIL kill_busy_in_div got=%b want=1", busy_s);
      end
      @(posedge clk);
      #1;
      set_nop();
      ex_opcode = 7'b0110011;
      @(negedge clk);
      checks++;
      if ({sel_s, busy_s, done_s} !== 3'b000) begin
         failures++;
         $display("FAIL kill_add_ctl got=%b%b%b want=000", sel_s, busy_s, done_s);
      end
      checks++;
      if (res_s !== last_res) begin
         failures++;
         $display("FAIL kill_result_hold got=%h want=%h", res_s, last_res);
      end
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done_s !== 1'b0 || busy_s !== 1'b0) saw_done++;
      end
      checks++;
      if (saw_done !== 0) begin
         failures++;
         $display("FAIL kill_no_done got=%0d want=0", saw_done);
      end
      @(posedge clk);
      #1;
      set_nop();
   endtask

   task automatic test_kill_start();
      set_mop(3'b000, 32'd3, 32'd4);
      ex_kill = 1'b1;
      @(negedge clk);
      checks++;
      if (busy_s !== 1'b0) begin
         failures++;
         $display("FAIL kill_start_busy got=%b want=0", busy_s);
      end
      @(posedge clk);
      #1;
      set_nop();
      @(negedge clk);
      checks++;
      if ({busy_s, done_s} !== 2'b00) begin
         failures++;
         $display("FAIL kill_start_after got=%b%b want=00", busy_s, done_s);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      run_op("b2b_mulhu", 1'b0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
      run_op("b2b_divu",  1'b0, 3'b101, 32'd100,      32'd7,        32'h0000000E, 33);
   endtask

   task automatic test_flush();
      set_mop(3'b100, 32'd9, 32'd3);
      ex_flush = 1'b1;
      @(negedge clk);
      checks++;
      if ({sel_s, busy_s} !== 2'b00) begin
         failures++;
         $display("FAIL flush_ctl got=%b%b want=00", sel_s, busy_s);
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if ({busy_s, done_s} !== 2'b00) begin
         failures++;
         $display("FAIL flush_after got=%b%b want=00", busy_s, done_s);
      end
      @(posedge clk);
      #1;
      set_nop();
   endtask

   task automatic test_reset_mid();
      set_mop(3'b000, 32'd5, 32'd6);
      repeat (6) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      set_nop();
      @(negedge clk);
      checks++;
      if ({busy_s, done_s, res_s} !== 34'd0) begin
         failures++;
         $display("FAIL reset_mid got=%b%b_%h want=00_00000000", busy_s, done_s, res_s);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      last_res = 32'd0;
      rst      = 1'b1;
      set_nop();
      @(posedge clk);
      #1;
      test_reset();
      test_fast_mul();
      test_mul();
      test_div();
      test_special();
      test_kill();
      test_kill_start();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
